// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, fetch FSM states and the IF/ID payload.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HOLD
    } lc3b_fetch_state;

    typedef struct packed {
        logic     valid;
        lc3b_word ir;
        lc3b_word pc;
    } lc3b_if_id;

    function automatic lc3b_word pc_plus2(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats load, a stalled live entry is frozen,
// an unstalled entry with nothing new behind it drains to invalid.
module if_id_register
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load_i,
    input  logic      flush_i,
    input  logic      stall_i,
    input  lc3b_if_id d_i,
    output lc3b_if_id q_o
);

    lc3b_if_id q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (flush_i) begin
            q_q.valid <= 1'b0;
        end else if (load_i) begin
            q_q <= d_i;
        end else if (!(stall_i && q_q.valid)) begin
            q_q.valid <= 1'b0;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction fetch: PC, single-outstanding imem request, one-entry
// skid buffer for decode stalls, and redirect handling with stale-response drain.
module lc3b_fetch_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_ir,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        pc_q, pc_d;
    lc3b_word        req_addr_q, req_addr_d;
    lc3b_word        buf_ir_q, buf_ir_d;
    lc3b_word        buf_pc_q, buf_pc_d;
    lc3b_if_id       ifid_q, ifid_d;
    logic            ifid_load;
    logic            slot_free;

    assign slot_free = !ifid_q.valid || !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_ir_q   <= '0;
            buf_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_ir_q   <= buf_ir_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_ir_d   = buf_ir_q;
        buf_pc_d   = buf_pc_q;
        ifid_load  = 1'b0;
        ifid_d     = '{valid: 1'b1, ir: imem_rdata, pc: req_addr_q};
        imem_read  = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_read = 1'b1;
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_resp) req_addr_d = redirect_pc;
                    else           state_d    = DRAIN;
                end else if (imem_resp) begin
                    pc_d = pc_plus2(req_addr_q);
                    if (slot_free) begin
                        ifid_load  = 1'b1;
                        req_addr_d = pc_plus2(req_addr_q);
                    end else begin
                        buf_ir_d = imem_rdata;
                        buf_pc_d = req_addr_q;
                        state_d  = HOLD;
                    end
                end
            end
            DRAIN: begin
                // Keep the stale address on the bus until its response lands.
                imem_read = 1'b1;
                if (redirect) pc_d = redirect_pc;
                if (imem_resp) begin
                    req_addr_d = redirect ? redirect_pc : pc_q;
                    state_d    = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_d     = '{valid: 1'b1, ir: buf_ir_q, pc: buf_pc_q};
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    if_id_register u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .flush_i (redirect),
        .stall_i (stall),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign imem_address = req_addr_q;
    assign if_valid     = ifid_q.valid;
    assign if_ir        = ifid_q.ir;
    assign if_pc        = ifid_q.pc;
    assign if_pc_plus2  = pc_plus2(ifid_q.pc);

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Directed bench for lc3b_fetch_stage with a transaction-level reference model
// (delivery queue plus expected fetch address) checked every cycle.
module tb_lc3b_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_ir        (if_ir),
        .if_pc        (if_pc),
        .if_pc_plus2  (if_pc_plus2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memw(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what IF/ID should show and what address should be on the bus.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
    } instr_t;

    instr_t      pend[$];
    instr_t      cur;
    bit          armed = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] m_pc = '0;
    logic [15:0] m_ir = '0;
    logic [15:0] m_plus2;
    bit          drain = 1'b0;
    logic [15:0] drain_addr = '0;
    logic [15:0] exp_addr = '0;
    bit          m_read;
    bit          accepted;

    always @(negedge clk) begin
        if (armed) begin
            chk("model if_valid", {15'd0, if_valid}, {15'd0, m_valid});
            if (m_valid) begin
                m_plus2 = m_pc + 16'd2;
                chk("model if_pc", if_pc, m_pc);
                chk("model if_ir", if_ir, m_ir);
                chk("model if_pc_plus2", if_pc_plus2, m_plus2);
            end
            chk("model imem_read", {15'd0, imem_read}, {15'd0, pend.size() == 0});
            if (pend.size() == 0)
                chk("model imem_address", imem_address, drain ? drain_addr : exp_addr);
        end
        #4;
        m_read = (pend.size() == 0);
        if (reset) begin
            m_valid  = 1'b0;
            pend.delete();
            drain    = 1'b0;
            exp_addr = 16'h0000;
            armed    = 1'b1;
        end else if (armed) begin
            accepted = m_read && imem_resp && !redirect && !drain;
            if (redirect) begin
                m_valid = 1'b0;
                pend.delete();
                if (m_read && !imem_resp) begin
                    if (!drain) drain_addr = exp_addr;
                    drain = 1'b1;
                end else begin
                    drain = 1'b0;
                end
                exp_addr = redirect_pc;
            end else begin
                if (drain && imem_resp) drain = 1'b0;
                if (m_valid && stall) begin
                    if (accepted) pend.push_back('{exp_addr, memw(exp_addr)});
                end else if (pend.size() != 0) begin
                    cur     = pend.pop_front();
                    m_valid = 1'b1;
                    m_pc    = cur.pc;
                    m_ir    = cur.ir;
                end else if (accepted) begin
                    m_valid = 1'b1;
                    m_pc    = exp_addr;
                    m_ir    = memw(exp_addr);
                end else begin
                    m_valid = 1'b0;
                end
                if (accepted) exp_addr = exp_addr + 16'd2;
            end
        end
    end

    // Memory: answers after `lat` wait cycles; stimulus changes 2ns after negedge.
    int lat = 0;
    int cnt = 0;

    task automatic step(input logic rst, input logic s, input logic r, input logic [15:0] rp);
        @(negedge clk);
        #2;
        reset       = rst;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_resp   = !rst && imem_read && (cnt == lat);
        imem_rdata  = imem_resp ? memw(imem_address) : 16'h0000;
        cnt         = (rst || !imem_read || imem_resp) ? 0 : cnt + 1;
    endtask

    task automatic do_reset(input int l);
        lat = l;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        // Zero-wait streaming from reset.
        do_reset(0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("reset if_valid", {15'd0, if_valid}, 16'd0);
        chk("reset imem_read", {15'd0, imem_read}, 16'd1);
        chk("reset imem_address", imem_address, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("stream pc0", if_pc, 16'h0000);
        chk("stream ir0", if_ir, 16'hBEEF);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("stream pc2", if_pc, 16'h0002);
        chk("stream ir2", if_ir, 16'hBEED);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("stream pc4", if_pc, 16'h0004);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("stream pc6", if_pc, 16'h0006);
        chk("stream valid", {15'd0, if_valid}, 16'd1);

        // Stall absorbed by the skid buffer.
        do_reset(0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("stall addr4", imem_address, 16'h0004);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("hold pc", if_pc, 16'h0002);
        chk("hold read", {15'd0, imem_read}, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("hold pc late", if_pc, 16'h0002);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("release pc4", if_pc, 16'h0004);
        chk("release addr6", imem_address, 16'h0006);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("release pc6", if_pc, 16'h0006);

        // Redirect while a slow request is outstanding.
        do_reset(2);
        idle(13);
        chk("slow addr8", imem_address, 16'h0008);
        step(1'b0, 1'b0, 1'b1, 16'h0100);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("drain addr8", imem_address, 16'h0008);
        chk("drain invalid", {15'd0, if_valid}, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("drain new addr", imem_address, 16'h0100);
        idle(3);
        chk("drain target pc", if_pc, 16'h0100);

        // Redirect, response and stall in the same cycle.
        do_reset(0);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 16'h0040);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("collide invalid", {15'd0, if_valid}, 16'd0);
        chk("collide addr", imem_address, 16'h0040);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("collide pc", if_pc, 16'h0040);

        // Redirect from HOLD, then wrap at the top of memory.
        do_reset(0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0200);
        chk("holdredir read", {15'd0, imem_read}, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("holdredir invalid", {15'd0, if_valid}, 16'd0);
        chk("holdredir addr", imem_address, 16'h0200);
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        chk("holdredir pc", if_pc, 16'h0200);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap addr", imem_address, 16'hFFFE);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap pc", if_pc, 16'hFFFE);
        chk("wrap plus2", if_pc_plus2, 16'h0000);
        chk("wrap next addr", imem_address, 16'h0000);
        idle(3);

        // Reset while a request is outstanding.
        do_reset(2);
        idle(1);
        do_reset(0);
        idle(3);
        chk("rereset pc", if_pc, 16'h0002);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lc3b_fetch_stage.md
# lc3b_fetch_stage

Instruction-fetch (IF) stage of the pipelined LC-3b core. It owns the PC and drives the instruction-memory port with a single outstanding request. It delivers fetched instructions through the IF/ID register to the decode stage, which expands opcodes into the `lc3b_control` word. Downstream stalls are absorbed with a one-entry skid buffer. Redirects (taken branch, JMP/JSR, TRAP) from later stages flush in-flight work.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `clk`, in, 1: clock; all state updates on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `imem_read`, out, 1: instruction-memory read request.
- `imem_address`, out, 16 (`lc3b_word`): request address; stable while `imem_read` is high until `imem_resp`.
- `imem_resp`, in, 1: memory response; `imem_rdata` is valid this cycle.
- `imem_rdata`, in, 16 (`lc3b_word`): instruction word.
- `stall`, in, 1: decode cannot accept; IF/ID holds.
- `redirect`, in, 1: flush and refetch from `redirect_pc`.
- `redirect_pc`, in, 16: redirect target.
- `if_valid`, out, 1: IF/ID holds a live instruction.
- `if_ir`, out, 16: instruction word.
- `if_pc`, out, 16: address of `if_ir`.
- `if_pc_plus2`, out, 16: `if_pc + 2`, modulo 2^16.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: drives `imem_address`.
  - IF/ID: `if_valid`, `if_ir`, `if_pc`.
  - Skid buffer: `buf_ir`, `buf_pc`.
  - FSM state.
- Reset:
  - `pc` and `req_addr` load RESET_PC.
  - `if_valid` goes to 0; `if_ir`, `if_pc`, `buf_*` go to 0.
  - State goes to FETCH.
- The slot is free when `!if_valid || !stall`.
- FETCH (`imem_read` = 1):
  - `imem_resp && !redirect` with slot free: IF/ID loads {rdata, req_addr}; `pc` and `req_addr` take `req_addr + 2`; stay in FETCH.
  - `imem_resp && !redirect` with slot busy: buffer loads {rdata, req_addr}; `pc` takes `req_addr + 2`; go to HOLD.
  - `redirect && imem_resp`: data discarded; `pc` and `req_addr` take `redirect_pc`; stay in FETCH.
  - `redirect && !imem_resp`: `pc` takes `redirect_pc`; `req_addr` unchanged; go to DRAIN.
- DRAIN (`imem_read` = 1, old address): the outstanding request completes without violating the memory protocol.
  - On `imem_resp`, data is discarded, `req_addr` takes `pc`, and the FSM goes to FETCH.
  - A further `redirect` in DRAIN overwrites `pc`; the latest redirect wins.
- HOLD (`imem_read` = 0):
  - `!stall && !redirect`: IF/ID loads from the buffer; `req_addr` takes `pc`; go to FETCH.
  - `redirect`: buffer discarded; `pc` and `req_addr` take `redirect_pc`; go to FETCH.
- IF/ID update rules:
  - Any cycle with `redirect`: `if_valid` goes to 0 next cycle. Redirect has priority over stall and over any load.
  - `if_valid && !stall` with no new load: `if_valid` goes to 0.
  - `stall && if_valid`: IF/ID contents are frozen.
- Arithmetic: PC increments are 16-bit and wrap 16'hFFFE to 16'h0000. Bit 0 of `redirect_pc` is passed through unchanged; alignment is not checked.

## Timing
- First cycle after reset deasserts: `imem_read` = 1 and `imem_address` = RESET_PC (Moore output of FETCH).
- `imem_resp` in cycle N leads to `if_valid` = 1 in cycle N+1.
- `imem_resp` may arrive in the same cycle `imem_read` rises. In that case `imem_read` stays high and the address advances, giving one instruction per cycle.
- `redirect` in cycle N:
  - `if_valid` = 0 in N+1.
  - If no request is outstanding, `imem_address` = `redirect_pc` in N+1.
  - In DRAIN, the new address appears the cycle after the stale `imem_resp`.
- HOLD to FETCH: the buffered instruction is in IF/ID one cycle after `stall` falls. The next request starts in that same cycle.
- Reset asserted mid-transaction: the state is forced to FETCH at RESET_PC and the outstanding response is not tracked. The memory model must be reset together with the core.

## Structure
- Add to `lc3b_types`:
  - `lc3b_fetch_state` enum {FETCH, DRAIN, HOLD}.
  - A packed struct `lc3b_if_id` {valid, ir, pc}, used as the IF/ID payload.
- One sub-module: `if_id_register`. It is a parameterless `lc3b_if_id` register with `load`, `flush` and `stall` inputs and synchronous reset. The FSM, PC and skid buffer stay in `lc3b_fetch_stage`.

## Test plan
- **Reset, zero-wait memory:** RESET_PC=16'h0000 with memory responding every cycle. Required: `if_pc` = 0, 2, 4, 6 on consecutive cycles from cycle 1, `if_ir` matches memory, `if_valid` constant 1.
- **Stall absorb:** `stall` high for 3 cycles while a response for 16'h0004 arrives. Required: `if_ir`/`if_pc` frozen at 16'h0002, state HOLD, `imem_read` = 0. On release, `if_pc` = 16'h0004 next cycle, then a fetch of 16'h0006.
- **Redirect during outstanding request:** 3-cycle memory latency, redirect to 16'h0100 one cycle after the request to 16'h0008. Required: address stays 16'h0008 until resp, data is dropped, next `imem_address` = 16'h0100, and `if_pc` never shows 16'h0008.
- **Redirect colliding with resp and stall:** `redirect`, `imem_resp` and `stall` all asserted in one cycle, target 16'h0040. Required: `if_valid` = 0 next cycle and `imem_address` = 16'h0040.
- **Redirect in HOLD and wrap:** redirect to 16'h0200 while in HOLD. Required: the buffered word is never presented and the next `if_pc` = 16'h0200. Separately, redirect to 16'hFFFE. Required: `if_pc_plus2` = 16'h0000 and the following fetch address is 16'h0000.
